regs_mp: RTL and testbench

// - Parametrised multi-port register file; next generation of the 32x32 CPU register file.
// - Adds N_RD read ports, a second full-word write port, byte-enabled writes on port 0,

---
 rtl/regs_mp.sv | 108 ++++++++++
 tb/tb_regs_mp.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regs_mp.sv
// Multi-port register file: N_RD combinational read ports, a byte-enabled write port,
// a full-word write port, optional write-to-read forwarding and a sequenced clear engine.
module regs_mp #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int N_RD    = 2,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     L_S,
  input  logic [ADDR_W-1:0]        Wt_addr,
  input  logic [DATA_W-1:0]        Wt_data,
  input  logic [DATA_W/8-1:0]      Wt_be,
  input  logic                     L_S1,
  input  logic [ADDR_W-1:0]        Wt_addr1,
  input  logic [DATA_W-1:0]        Wt_data1,
  input  logic [N_RD*ADDR_W-1:0]   R_addr,
  output logic [N_RD*DATA_W-1:0]   rdata,
  input  logic                     clr_req,
  output logic                     clr_busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int NB    = DATA_W / 8;

  typedef enum logic {IDLE, CLR} state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   cnt_reg, cnt_next;
  logic [DATA_W-1:0]   mem_reg   [DEPTH];
  logic [DATA_W-1:0]   next_word [DEPTH];

  assign clr_busy = (state_reg == CLR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Exit on the all-ones address; the counter then wraps naturally to 0.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (clr_req) begin
          state_next = CLR;
          cnt_next   = '0;
        end
      end
      CLR: begin
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == {ADDR_W{1'b1}}) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Post-write value of every entry: port 0 bytes merged first, then port 1 overrides.
  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      next_word[e] = mem_reg[e];
      if (!(ZERO_R0 != 0 && e == 0)) begin
        if (L_S && Wt_addr == ADDR_W'(e)) begin
          for (int b = 0; b < NB; b++) begin
            if (Wt_be[b]) next_word[e][b*8 +: 8] = Wt_data[b*8 +: 8];
          end
        end
        if (L_S1 && Wt_addr1 == ADDR_W'(e)) next_word[e] = Wt_data1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int e = 0; e < DEPTH; e++) mem_reg[e] <= '0;
    end else if (clr_busy) begin
      mem_reg[cnt_reg] <= '0;
    end else begin
      for (int e = 0; e < DEPTH; e++) mem_reg[e] <= next_word[e];
    end
  end

  generate
    for (genvar gi = 0; gi < N_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] val;

      assign addr = R_addr[gi*ADDR_W +: ADDR_W];

      always_comb begin
        if (BYPASS != 0 && !clr_busy) val = next_word[addr];
        else                          val = mem_reg[addr];
        if (!rst || (ZERO_R0 != 0 && addr == '0)) val = '0;
      end

      assign rdata[gi*DATA_W +: DATA_W] = val;
    end
  endgenerate

endmodule

// File: tb/tb_regs_mp.sv
// Bench for regs_mp: a forwarding and a non-forwarding instance share stimulus and are
// compared every cycle against an array model, plus directed literal checks.
module tb_regs_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic        L_S, L_S1, clr_req;
  logic [4:0]  Wt_addr, Wt_addr1;
  logic [31:0] Wt_data, Wt_data1;
  logic [3:0]  Wt_be;
  logic [9:0]  R_addr;
  logic [63:0] rdata_b, rdata_n;
  logic        busy_b, busy_n;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_mem [32];
  int          clr_idx = -1;

  always #5 clk = ~clk;

  regs_mp #(.BYPASS(1)) u_byp (
    .clk(clk), .rst(rst), .L_S(L_S), .Wt_addr(Wt_addr), .Wt_data(Wt_data), .Wt_be(Wt_be),
    .L_S1(L_S1), .Wt_addr1(Wt_addr1), .Wt_data1(Wt_data1), .R_addr(R_addr),
    .rdata(rdata_b), .clr_req(clr_req), .clr_busy(busy_b)
  );

  regs_mp #(.BYPASS(0)) u_nobyp (
    .clk(clk), .rst(rst), .L_S(L_S), .Wt_addr(Wt_addr), .Wt_data(Wt_data), .Wt_be(Wt_be),
    .L_S1(L_S1), .Wt_addr1(Wt_addr1), .Wt_data1(Wt_data1), .R_addr(R_addr),
    .rdata(rdata_n), .clr_req(clr_req), .clr_busy(busy_n)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // Value a register holds once this cycle's writes land.
  function automatic logic [31:0] post_val(input logic [4:0] a);
    logic [31:0] v;
    v = m_mem[a];
    if (L_S && Wt_addr == a)
      for (int b = 0; b < 4; b++) if (Wt_be[b]) v[b*8 +: 8] = Wt_data[b*8 +: 8];
    if (L_S1 && Wt_addr1 == a) v = Wt_data1;
    return v;
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] a, input bit byp);
    if (!rst || a == 5'd0) return 32'h0;
    if (byp && clr_idx < 0) return post_val(a);
    return m_mem[a];
  endfunction

  task automatic model_step();
    if (!rst) begin
      for (int e = 0; e < 32; e++) m_mem[e] = 32'h0;
      clr_idx = -1;
    end else if (clr_idx >= 0) begin
      m_mem[clr_idx] = 32'h0;
      clr_idx++;
      if (clr_idx == 32) clr_idx = -1;
    end else begin
      if (L_S && Wt_addr != 5'd0)
        for (int b = 0; b < 4; b++) if (Wt_be[b]) m_mem[Wt_addr][b*8 +: 8] = Wt_data[b*8 +: 8];
      if (L_S1 && Wt_addr1 != 5'd0) m_mem[Wt_addr1] = Wt_data1;
      if (clr_req) clr_idx = 0;
    end
  endtask

  initial for (int e = 0; e < 32; e++) m_mem[e] = 32'h0;

  always @(negedge clk) begin
    logic [4:0] a;
    logic       eb;
    for (int p = 0; p < 2; p++) begin
      a = R_addr[p*5 +: 5];
      chk($sformatf("byp_rd%0d", p), {32'h0, rdata_b[p*32 +: 32]}, {32'h0, exp_read(a, 1'b1)});
      chk($sformatf("nobyp_rd%0d", p), {32'h0, rdata_n[p*32 +: 32]}, {32'h0, exp_read(a, 1'b0)});
    end
    eb = rst && (clr_idx >= 0);
    chk("busy_byp", {63'h0, busy_b}, {63'h0, eb});
    chk("busy_nobyp", {63'h0, busy_n}, {63'h0, eb});
    model_step();
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    L_S = 1'b0; L_S1 = 1'b0; clr_req = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b0; idle_in();
    Wt_addr = '0; Wt_addr1 = '0; Wt_data = '0; Wt_data1 = '0; Wt_be = '0; R_addr = '0;
    repeat (3) tick();
    @(negedge clk);
    chk("reset_busy", {63'h0, busy_b}, 64'h0);
    chk("reset_rdata", rdata_b, 64'h0);
    tick();
    rst = 1'b1;
    tick();

    // Two writes in one cycle, then read both back
    L_S = 1'b1; Wt_addr = 5'd5; Wt_data = 32'h12345678; Wt_be = 4'hF;
    L_S1 = 1'b1; Wt_addr1 = 5'd6; Wt_data1 = 32'h87654321;
    tick();
    idle_in(); R_addr = {5'd6, 5'd5};
    chk("model_r5", {32'h0, m_mem[5]}, 64'h12345678);
    @(negedge clk);
    chk("rd_r5", {32'h0, rdata_b[31:0]}, 64'h12345678);
    chk("rd_r6", {32'h0, rdata_b[63:32]}, 64'h87654321);
    $display("txn write r5/r6 read %h %h", rdata_b[31:0], rdata_b[63:32]);
    tick();

    // Same-cycle forwarding
    L_S = 1'b1; Wt_addr = 5'd7; Wt_data = 32'hDEADBEEF; Wt_be = 4'hF; R_addr = {5'd7, 5'd7};
    @(negedge clk);
    chk("byp_same_cycle", {32'h0, rdata_b[31:0]}, 64'hDEADBEEF);
    chk("nobyp_old", {32'h0, rdata_n[31:0]}, 64'h0);
    $display("txn write r7 same-cycle byp=%h nobyp=%h", rdata_b[31:0], rdata_n[31:0]);
    tick();
    idle_in();
    @(negedge clk);
    chk("nobyp_next", {32'h0, rdata_n[31:0]}, 64'hDEADBEEF);
    tick();

    // Byte-enabled merge
    L_S = 1'b1; Wt_addr = 5'd9; Wt_data = 32'h12345678; Wt_be = 4'hF;
    tick();
    Wt_data = 32'hAABBCCDD; Wt_be = 4'b0101;
    tick();
    idle_in(); R_addr = {5'd9, 5'd9};
    chk("model_r9", {32'h0, m_mem[9]}, 64'h12BB56DD);
    @(negedge clk);
    chk("be_merge", {32'h0, rdata_b[31:0]}, 64'h12BB56DD);
    $display("txn byte write r9 -> %h", rdata_b[31:0]);
    tick();

    // Dual write collision, then writes to r0
    L_S = 1'b1; Wt_addr = 5'd3; Wt_data = 32'h11111111; Wt_be = 4'hF;
    L_S1 = 1'b1; Wt_addr1 = 5'd3; Wt_data1 = 32'h22222222;
    tick();
    idle_in(); R_addr = {5'd3, 5'd3};
    @(negedge clk);
    chk("dual_write", {32'h0, rdata_n[31:0]}, 64'h22222222);
    $display("txn dual write r3 -> %h", rdata_n[31:0]);
    tick();
    L_S = 1'b1; Wt_addr = 5'd0; Wt_data = 32'hFFFFFFFF;
    L_S1 = 1'b1; Wt_addr1 = 5'd0; Wt_data1 = 32'hFFFFFFFF; R_addr = {5'd0, 5'd0};
    @(negedge clk);
    chk("r0_byp", rdata_b, 64'h0);
    tick();
    idle_in();
    @(negedge clk);
    chk("r0_after", rdata_n, 64'h0);
    $display("txn write r0 -> %h", rdata_n[31:0]);
    tick();

    // Full clear with a write issued mid-sequence
    for (int a = 1; a < 32; a++) begin
      L_S1 = 1'b1; Wt_addr1 = 5'(a); Wt_data1 = $urandom | 32'h1;
      tick();
    end
    idle_in(); clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!busy_b) break;
      n++;
      tick();
      if (n == 5) begin
        L_S = 1'b1; Wt_addr = 5'd4; Wt_data = 32'hCAFEF00D; Wt_be = 4'hF;
      end else begin
        L_S = 1'b0;
      end
    end
    chk("clr_cycles", 64'(n), 64'd32);
    $display("txn clear busy cycles=%0d", n);
    tick();
    idle_in();
    for (int a = 0; a < 32; a++) begin
      R_addr = {5'(a), 5'(a)};
      @(negedge clk);
      chk($sformatf("cleared_r%0d", a), rdata_n, 64'h0);
      tick();
    end

    // Reset in the middle of a clear
    for (int a = 1; a < 11; a++) begin
      L_S1 = 1'b1; Wt_addr1 = 5'(a); Wt_data1 = 32'hA5000000 | 32'(a);
      tick();
    end
    idle_in(); clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (10) tick();
    rst = 1'b0; R_addr = {5'd20, 5'd10};
    @(negedge clk);
    chk("rst_mid_busy", {63'h0, busy_b}, 64'h0);
    chk("rst_mid_rdata", rdata_n, 64'h0);
    $display("txn reset mid-clear busy=%b", busy_b);
    tick();
    tick();
    rst = 1'b1;
    L_S = 1'b1; Wt_addr = 5'd5; Wt_data = 32'h5A5A5A5A; Wt_be = 4'hF; R_addr = {5'd10, 5'd5};
    tick();
    idle_in();
    @(negedge clk);
    chk("post_rst_r5", {32'h0, rdata_n[31:0]}, 64'h5A5A5A5A);
    chk("post_rst_r10", {32'h0, rdata_n[63:32]}, 64'h0);
    $display("txn write r5 after reset -> %h", rdata_n[31:0]);
    tick();

    // Randomised traffic
    for (int c = 0; c < 2000; c++) begin
      L_S      = 1'($urandom_range(0, 1));
      L_S1     = 1'($urandom_range(0, 1));
      Wt_addr  = 5'($urandom);
      Wt_addr1 = ($urandom_range(0, 3) == 0) ? Wt_addr : 5'($urandom);
      Wt_data  = $urandom;
      Wt_data1 = $urandom;
      Wt_be    = 4'($urandom);
      for (int p = 0; p < 2; p++) begin
        case ($urandom_range(0, 2))
          0:       R_addr[p*5 +: 5] = Wt_addr;
          1:       R_addr[p*5 +: 5] = Wt_addr1;
          default: R_addr[p*5 +: 5] = 5'($urandom);
        endcase
      end
      clr_req = ($urandom_range(0, 149) == 0);
      rst     = ($urandom_range(0, 399) != 0);
      tick();
    end
    idle_in(); rst = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
